sc_ifu: RTL

SC_IFU -- requirements
Module: sc_ifu

---
 rtl/sc_ifu.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sc_ifu.sv
// Single-cycle CPU instruction fetch unit: IDLE/REQ/EXEC/HALT fetch sequencer with next-PC mux and fetch timeout.
// Optional macro SC_IFU_ALIGN_CHECK_EN: misaligned next PC halts with err instead of being truncated.
module sc_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  MAX_WAIT = 8'd255
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        inst_valid,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        err
);

  localparam int unsigned XW = 32;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_HALT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [XW-1:0] r_pc;
  logic [XW-1:0] r_inst;
  logic [WW-1:0] r_wait;
  logic          r_err;
  logic          r_req;
  logic          r_valid;
  logic [XW-1:0] w_pc4;
  logic [XW-1:0] w_target;
  logic [XW-1:0] w_next_pc;
  logic          w_timeout;
  logic          w_load_inst;
  logic          w_load_pc;
  logic          w_fault;

  assign w_pc4     = r_pc + 32'd4;
  assign w_timeout = (9'(r_wait) + 9'd1) >= 9'(MAX_WAIT);

  // Next-PC select; all sums wrap modulo 2^32
  always_comb begin
    w_target = w_pc4;
    case (pcsource)
      2'b00: w_target = w_pc4;
      2'b01: w_target = w_pc4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
      2'b10: w_target = ra;
      2'b11: w_target = {w_pc4[31:28], r_inst[25:0], 2'b00};
      default: w_target = w_pc4;
    endcase
  end

  assign w_next_pc = w_target & ~32'h0000_0003;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_inst = 1'b0;
    w_load_pc   = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        // Ack wins over a timeout landing in the same cycle
        if (imem_ack) begin
          w_next      = S_EXEC;
          w_load_inst = 1'b1;
        end else if (w_timeout) begin
          w_next  = S_HALT;
          w_fault = 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall) begin
`ifdef SC_IFU_ALIGN_CHECK_EN
          if (|w_target[1:0]) begin
            w_next  = S_HALT;
            w_fault = 1'b1;
          end else begin
            w_next    = S_REQ;
            w_load_pc = 1'b1;
          end
`else
          w_next    = S_REQ;
          w_load_pc = 1'b1;
`endif
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_wait  <= 8'h0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_req   <= (w_next == S_REQ);
      r_valid <= (w_next == S_EXEC);
      if (w_load_inst) r_inst <= imem_rdata;
      if (w_load_pc)   r_pc   <= w_next_pc;
      if (w_fault)     r_err  <= 1'b1;
      // Counter idles at zero outside REQ so each REQ entry starts fresh
      if (r_state != S_REQ)  r_wait <= 8'h0;
      else if (!imem_ack)    r_wait <= r_wait + 8'd1;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign op         = r_inst[31:26];
  assign func       = r_inst[5:0];
  assign inst_valid = r_valid;
  assign pc         = r_pc;
  assign pc4        = w_pc4;
  assign err        = r_err;

endmodule
